// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 echo emulator: measures the trigger pulse, then after a fixed
// settle delay answers with an echo pulse whose width encodes the target
// distance (58 us per cm), followed by a dead time before re-arming.
module hcsr04_echo_responder #(
    parameter int CLKS_PER_US = 100,
    parameter int MIN_TRIG_US = 10,
    parameter int SETTLE_US   = 200,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] distance_cm,
    input  logic        object_present,
    output logic        echo,
    output logic        busy,
    output logic        trig_err
);

    localparam int TW  = 32;
    localparam int WCW = $clog2(MIN_TRIG_US * CLKS_PER_US + 1);

    localparam logic [WCW-1:0] MIN_CLKS     = WCW'(MIN_TRIG_US * CLKS_PER_US);
    localparam logic [TW-1:0]  SETTLE_CLKS  = TW'(SETTLE_US * CLKS_PER_US);
    localparam logic [TW-1:0]  HOLDOFF_CLKS = TW'(HOLDOFF_US * CLKS_PER_US);
    localparam logic [TW-1:0]  TIMEOUT_W    = TW'(TIMEOUT_US);
    localparam logic [TW-1:0]  CPU_W        = TW'(CLKS_PER_US);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG_MEAS = 3'd1,
        S_SETTLE    = 3'd2,
        S_ECHO      = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    state_t         r_state;
    logic           r_sync1, r_sync2, r_trig_d;
    logic [WCW-1:0] r_wcnt;
    logic [TW-1:0]  r_timer;
    logic [TW-1:0]  r_width_us;
    logic           r_echo, r_busy, r_trig_err;

    logic           w_rise, w_fall;
    logic [23:0]    w_dist_eff;
    logic [23:0]    w_prod;
    logic [TW-1:0]  w_width_us;

    assign w_rise   = r_sync2 & ~r_trig_d;
    assign w_fall   = ~r_sync2 & r_trig_d;
    assign echo     = r_echo;
    assign busy     = r_busy;
    assign trig_err = r_trig_err;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_trig_d <= 1'b0;
        end else begin
            r_sync1  <= trigger;
            r_sync2  <= r_sync1;
            r_trig_d <= r_sync2;
        end
    end

    // Echo width in us: distance 0 reads as 1 cm; 24-bit product holds 65535*58.
    always_comb begin
        w_dist_eff = (distance_cm == 16'd0) ? 24'd1 : {8'd0, distance_cm};
        w_prod     = w_dist_eff * 24'd58;
        if (!object_present || (TW'(w_prod) > TIMEOUT_W))
            w_width_us = TIMEOUT_W;
        else
            w_width_us = TW'(w_prod);
    end

    // Main sequencer; all outputs registered so echo/busy never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_timer    <= '0;
            r_width_us <= '0;
            r_echo     <= 1'b0;
            r_busy     <= 1'b0;
            r_trig_err <= 1'b0;
        end else begin
            r_trig_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The rise cycle itself is the first high cycle of the pulse.
                    if (w_rise) begin
                        r_state <= S_TRIG_MEAS;
                        r_wcnt  <= WCW'(1);
                    end else begin
                        r_wcnt  <= '0;
                    end
                end
                S_TRIG_MEAS: begin
                    if (w_fall) begin
                        r_wcnt <= '0;
                        if (r_wcnt >= MIN_CLKS) begin
                            r_width_us <= w_width_us;
                            r_timer    <= SETTLE_CLKS - 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_SETTLE;
                        end else begin
                            r_trig_err <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end else if (r_sync2 && (r_wcnt < MIN_CLKS)) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_timer == '0) begin
                        r_echo  <= 1'b1;
                        r_timer <= r_width_us * CPU_W - 1'b1;
                        r_state <= S_ECHO;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_ECHO: begin
                    if (r_timer == '0) begin
                        r_echo  <= 1'b0;
                        r_timer <= HOLDOFF_CLKS - 1'b1;
                        r_state <= S_HOLDOFF;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    // A trigger still high here leaves r_trig_d set, so IDLE sees no rise.
                    if (r_timer == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_echo  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
